// File: rtl/fsm_ctrl_param.sv
// fsm_ctrl_param: FIFO-subsystem control FSM with threshold capture, idle dwell and sticky error tracking.
module fsm_ctrl_param #(
    parameter int NUM_FIFOS  = 8,
    parameter int UMBRAL_W   = 4,
    parameter int IDLE_DWELL = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [2*UMBRAL_W-1:0]   umbral_LH,
    input  logic [NUM_FIFOS-1:0]    empty_fifo,
    input  logic [NUM_FIFOS-1:0]    error_fifo,
    output logic [2:0]              state,
    output logic [2:0]              nxt_state,
    output logic [2*UMBRAL_W-1:0]   umbral_LH_out,
    output logic                    idle_out,
    output logic                    error_out,
    output logic [NUM_FIFOS-1:0]    error_vec
);
    localparam int CW = $clog2(IDLE_DWELL + 1);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t         cur, nxt;
    logic [CW-1:0]  dwell;
    logic           all_empty, any_err, dwell_done, thr_ok;

    assign all_empty  = &empty_fifo;
    assign any_err    = |error_fifo;
    assign dwell_done = all_empty && (dwell == CW'(IDLE_DWELL - 1));
    assign thr_ok     = umbral_LH[UMBRAL_W-1:0] <= umbral_LH[2*UMBRAL_W-1:UMBRAL_W];

    // Errors outrank init, which outranks the normal flow; illegal codes fall back to RESET.
    always_comb begin
        nxt = S_RESET;
        case (cur)
            S_RESET:  nxt = S_INIT;
            S_INIT:   nxt = any_err ? S_ERROR : init ? S_INIT : S_IDLE;
            S_IDLE:   nxt = any_err ? S_ERROR : init ? S_INIT : all_empty ? S_IDLE : S_ACTIVE;
            S_ACTIVE: nxt = any_err ? S_ERROR : init ? S_INIT : dwell_done ? S_IDLE : S_ACTIVE;
            S_ERROR:  nxt = S_ERROR;
            default:  nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur           <= S_RESET;
            umbral_LH_out <= '0;
            error_vec     <= '0;
            dwell         <= '0;
            idle_out      <= 1'b0;
            error_out     <= 1'b0;
        end else begin
            cur       <= nxt;
            idle_out  <= nxt == S_IDLE;
            error_out <= nxt == S_ERROR;
            if (cur == S_INIT && thr_ok)
                umbral_LH_out <= umbral_LH;
            if (cur != S_RESET)
                error_vec <= error_vec | error_fifo;
            dwell <= (cur == S_ACTIVE && nxt == S_ACTIVE && all_empty) ? dwell + 1'b1 : '0;
        end
    end

    assign state     = cur;
    assign nxt_state = nxt;
endmodule

// File: tb/tb_fsm_ctrl_param.sv
// tb_fsm_ctrl_param: vector table, corner sequences and randomized model checks on two parameterisations.
module tb_fsm_ctrl_param;
    logic        clk, reset;
    logic        ia, ib;
    logic [7:0]  ua, ea, ra;
    logic [11:0] ub;
    logic [2:0]  eb, rb;
    logic [2:0]  st_a, nx_a, st_b, nx_b;
    logic [7:0]  thr_a, ev_a;
    logic [11:0] thr_b;
    logic [2:0]  ev_b;
    logic        idle_a, err_a, idle_b, err_b;
    int          n_checks = 0, n_fail = 0;

    typedef struct {int st; int thr; int ev; int run;} mdl_t;
    typedef struct {bit ini; logic [7:0] umb, emp, err; int st; int thr; bit idle; bit er; int ev;} vec_t;

    mdl_t ma, mb, na, nb;
    vec_t tbl [19];

    fsm_ctrl_param dut_a (
        .clk(clk), .reset(reset), .init(ia), .umbral_LH(ua), .empty_fifo(ea), .error_fifo(ra),
        .state(st_a), .nxt_state(nx_a), .umbral_LH_out(thr_a), .idle_out(idle_a),
        .error_out(err_a), .error_vec(ev_a));

    fsm_ctrl_param #(.NUM_FIFOS(3), .UMBRAL_W(6), .IDLE_DWELL(1)) dut_b (
        .clk(clk), .reset(reset), .init(ib), .umbral_LH(ub), .empty_fifo(eb), .error_fifo(rb),
        .state(st_b), .nxt_state(nx_b), .umbral_LH_out(thr_b), .idle_out(idle_b),
        .error_out(err_b), .error_vec(ev_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input mdl_t m);
        chk({tag, " A state"}, st_a, m.st);
        chk({tag, " A thr"}, thr_a, m.thr);
        chk({tag, " A idle"}, idle_a, int'(m.st == 2));
        chk({tag, " A err"}, err_a, int'(m.st == 4));
        chk({tag, " A ev"}, ev_a, m.ev);
    endtask

    task automatic chk_b(input string tag, input mdl_t m);
        chk({tag, " B state"}, st_b, m.st);
        chk({tag, " B thr"}, thr_b, m.thr);
        chk({tag, " B idle"}, idle_b, int'(m.st == 2));
        chk({tag, " B err"}, err_b, int'(m.st == 4));
        chk({tag, " B ev"}, ev_b, m.ev);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: count consecutive all-empty cycles spent in ACTIVE and leave once d of them are seen.
    function automatic mdl_t step(mdl_t m, bit ini, int umb, int emp, int err, int n, int w, int d);
        mdl_t r = m;
        int nm = (1 << n) - 1;
        int wm = (1 << w) - 1;
        bit ae = (emp & nm) == nm;
        bit anyerr = (err & nm) != 0;
        if (m.st != 0) r.ev = m.ev | (err & nm);
        if (m.st == 1 && (umb & wm) <= ((umb >> w) & wm)) r.thr = umb & ((1 << (2 * w)) - 1);
        r.run = (m.st == 3 && ae) ? m.run + 1 : 0;
        if (m.st == 0) r.st = 1;
        else if (anyerr || m.st == 4) r.st = 4;
        else if (ini) r.st = 1;
        else if (m.st == 1) r.st = 2;
        else if (m.st == 2) r.st = ae ? 2 : 3;
        else r.st = (r.run >= d) ? 2 : 3;
        if (r.st != 3) r.run = 0;
        return r;
    endfunction

    initial begin
        tbl[0]  = '{1, 8'h62, 8'hFF, 8'h00, 1, 8'h00, 0, 0, 8'h00};
        tbl[1]  = '{1, 8'h62, 8'hFF, 8'h00, 1, 8'h62, 0, 0, 8'h00};
        tbl[2]  = '{1, 8'h35, 8'hFF, 8'h00, 1, 8'h62, 0, 0, 8'h00};
        tbl[3]  = '{0, 8'h35, 8'hFF, 8'h00, 2, 8'h62, 1, 0, 8'h00};
        tbl[4]  = '{0, 8'h35, 8'hF7, 8'h00, 3, 8'h62, 0, 0, 8'h00};
        tbl[5]  = '{0, 8'h35, 8'hFF, 8'h00, 3, 8'h62, 0, 0, 8'h00};
        tbl[6]  = '{0, 8'h35, 8'hFF, 8'h00, 2, 8'h62, 1, 0, 8'h00};
        tbl[7]  = '{0, 8'h35, 8'hF7, 8'h00, 3, 8'h62, 0, 0, 8'h00};
        tbl[8]  = '{0, 8'h35, 8'hFF, 8'h00, 3, 8'h62, 0, 0, 8'h00};
        tbl[9]  = '{0, 8'h35, 8'hFE, 8'h00, 3, 8'h62, 0, 0, 8'h00};
        tbl[10] = '{0, 8'h35, 8'hFF, 8'h00, 3, 8'h62, 0, 0, 8'h00};
        tbl[11] = '{0, 8'h35, 8'hFF, 8'h00, 2, 8'h62, 1, 0, 8'h00};
        tbl[12] = '{1, 8'h62, 8'h00, 8'h00, 1, 8'h62, 0, 0, 8'h00};
        tbl[13] = '{0, 8'h62, 8'h00, 8'h00, 2, 8'h62, 1, 0, 8'h00};
        tbl[14] = '{0, 8'h62, 8'h00, 8'h00, 3, 8'h62, 0, 0, 8'h00};
        tbl[15] = '{0, 8'h62, 8'h00, 8'h04, 4, 8'h62, 0, 1, 8'h04};
        tbl[16] = '{1, 8'h62, 8'h00, 8'h00, 4, 8'h62, 0, 1, 8'h04};
        tbl[17] = '{1, 8'h62, 8'h00, 8'h81, 4, 8'h62, 0, 1, 8'h85};
        tbl[18] = '{1, 8'h10, 8'h00, 8'h00, 4, 8'h62, 0, 1, 8'h85};

        reset = 0; ia = 0; ua = 0; ea = 8'hFF; ra = 0;
        ib = 0; ub = 0; eb = 3'b111; rb = 0;
        #1 reset = 1;
        #1;
        chk_a("reset", '{0, 0, 0, 0});
        chk_b("reset", '{0, 0, 0, 0});
        #10 reset = 0;

        foreach (tbl[i]) begin
            ia = tbl[i].ini; ua = tbl[i].umb; ea = tbl[i].emp; ra = tbl[i].err;
            #1;
            chk($sformatf("row%0d nxt", i), nx_a, tbl[i].st);
            tick();
            chk($sformatf("row%0d state", i), st_a, tbl[i].st);
            chk($sformatf("row%0d thr", i), thr_a, tbl[i].thr);
            chk($sformatf("row%0d idle", i), idle_a, tbl[i].idle);
            chk($sformatf("row%0d err", i), err_a, tbl[i].er);
            chk($sformatf("row%0d ev", i), ev_a, tbl[i].ev);
        end

        // Asynchronous reset between edges while in ERROR
        ia = 0; ua = 8'h10; ea = 8'hFF; ra = 0;
        #2 reset = 1;
        #1;
        chk_a("async", '{0, 0, 0, 0});
        chk("async B state", st_b, 0);
        #2 reset = 0;
        tick();
        chk_a("post1", '{1, 0, 0, 0});
        tick();
        chk_a("post2", '{2, 8'h10, 0, 0});

        // Second parameterisation: single-cycle dwell
        ib = 1; ub = 12'd1285;
        tick();
        chk_b("binit1", '{1, 0, 0, 0});
        tick();
        chk_b("binit2", '{1, 1285, 0, 0});
        ib = 0; ub = 12'd201;
        tick();
        chk_b("bidle", '{2, 1285, 0, 0});
        eb = 3'b101;
        tick();
        chk_b("bact", '{3, 1285, 0, 0});
        eb = 3'b111;
        tick();
        chk_b("bback", '{2, 1285, 0, 0});
        rb = 3'b010;
        tick();
        chk_b("berr", '{4, 1285, 2, 0});
        rb = 0;

        reset = 1;
        #1 reset = 0;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset = 1;
                #1;
                ma = '{0, 0, 0, 0};
                mb = '{0, 0, 0, 0};
                chk_a("rnd rst", ma);
                chk_b("rnd rst", mb);
                reset = 0;
                #1;
            end
            ia = $urandom_range(0, 7) == 0;
            ua = 8'($urandom);
            ea = $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'hFF;
            ra = $urandom_range(0, 149) == 0 ? 8'($urandom) : 8'h00;
            ib = $urandom_range(0, 7) == 0;
            ub = 12'($urandom);
            eb = $urandom_range(0, 2) == 0 ? 3'($urandom) : 3'b111;
            rb = $urandom_range(0, 149) == 0 ? 3'($urandom) : 3'b000;
            #1;
            na = step(ma, ia, int'(ua), int'(ea), int'(ra), 8, 4, 2);
            nb = step(mb, ib, int'(ub), int'(eb), int'(rb), 3, 6, 1);
            chk("rnd A nxt", nx_a, na.st);
            chk("rnd B nxt", nx_b, nb.st);
            tick();
            ma = na;
            mb = nb;
            chk_a("rnd", ma);
            chk_b("rnd", mb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
